ifetch_burst_buffer: RTL and testbench

- Parametrised next-generation instruction fetch front end.
- Fetches instructions over the AXI read channels with multi-beat INCR bursts.
- Unpacks each DATA_WIDTH beat into 32-bit instructions and buffers them in a prefetch FIFO.
- Presents one instruction per cycle to decode through a valid/ready handshake.
- Supports redirect (branch/jump) with flush and discard of in-flight beats.

---
 rtl/ifetch_burst_buffer_pkg.sv | 15 +
 rtl/ifetch_burst_buffer_if.sv | 46 ++++
 rtl/ifetch_burst_buffer_fifo.sv | 68 ++++++
 rtl/ifetch_burst_buffer.sv | 155 +++++++++++++++
 tb/tb_ifetch_burst_buffer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_burst_buffer_pkg.sv
// Shared types and AXI constants for the instruction fetch burst buffer.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         PAGE_BYTES = 4096;

endpackage

// File: rtl/ifetch_burst_buffer_if.sv
// AXI read channels plus decode and redirect signals of the fetch front end.
interface ifetch_burst_buffer_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [31:0]           if_instr;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  if_fault;
  logic                  if_valid;
  logic                  if_ready;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output if_instr, if_pc, if_fault, if_valid,
    input  if_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  if_instr, if_pc, if_fault, if_valid,
    output if_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifetch_burst_buffer_fifo.sv
// Prefetch FIFO: up to IPB entries pushed per cycle, one popped, synchronous flush.
module ifetch_fifo #(
  parameter int ENTRY_W = 97,
  parameter int DEPTH   = 16,
  parameter int IPB     = 2,
  localparam int PW     = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1,
  localparam int NUM_W  = $clog2(IPB) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [NUM_W-1:0]              push_n,
  input  logic [IPB-1:0][ENTRY_W-1:0]   push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [ENTRY_W-1:0]            head,
  output logic [CNT_W-1:0]              count
);

  logic [DEPTH-1:0][ENTRY_W-1:0] mem_q, mem_d;
  logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic                          pop_ok;

  assign pop_ok = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        for (int k = 0; k < IPB; k++) begin
          if (NUM_W'(k) < push_n) mem_d[wr_ptr_q + PW'(k)] = push_data[k];
        end
        wr_ptr_d = wr_ptr_q + PW'(push_n);
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (push ? CNT_W'(push_n) : '0) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Memory is not cleared on flush, so gate the head to keep outputs at zero when empty.
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/ifetch_burst_buffer.sv
// Instruction fetch front end: AXI INCR bursts unpacked into a prefetch FIFO.
// state | meaning
// IDLE  | wait for a full burst of free entries, then latch AR payload
// ADDR  | arvalid held until arready
// DATA  | rready high, beats unpacked and pushed
// DRAIN | rready high, beats of a redirected burst discarded
module ifetch_burst_buffer
  import ifetch_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] entry,
  ifetch_burst_buffer_if.master bus
);

  localparam int IPB        = DATA_WIDTH / 32;
  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int OFF_W      = $clog2(IPB);
  localparam int NUM_W      = $clog2(IPB) + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int RESERVE    = BURST_LEN * IPB;
  localparam int ENTRY_W    = 1 + ADDR_WIDTH + 32;

  fetch_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic                    drain_pend_q, drain_pend_d;

  logic                    push, flush, pop, rx_beat, beat_fault;
  logic [NUM_W-1:0]        push_n;
  logic [IPB-1:0][ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0]      head;
  logic [CNT_W-1:0]        fifo_count;
  logic [OFF_W-1:0]        slot_off;
  logic [OFF_W+4:0]        shift_amt;
  logic [DATA_WIDTH-1:0]   beat_shifted;
  logic [ADDR_WIDTH-1:0]   aligned_pc;
  logic [12:0]             beats_left;
  logic [7:0]              arlen_next;

  assign rx_beat    = bus.m_axi_rready && bus.m_axi_rvalid;
  assign beat_fault = (bus.m_axi_rresp != RESP_OKAY);
  // Slots below the PC offset are skipped; after the first beat the PC is beat-aligned.
  assign slot_off   = fetch_pc_q[BEAT_SHIFT-1:2];
  assign shift_amt  = {slot_off, 5'b0};
  assign beat_shifted = bus.m_axi_rdata >> shift_amt;
  assign push_n     = NUM_W'(IPB) - NUM_W'(slot_off);
  assign aligned_pc = {fetch_pc_q[ADDR_WIDTH-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
  assign beats_left = (13'(PAGE_BYTES) - {1'b0, aligned_pc[11:0]}) >> BEAT_SHIFT;
  assign arlen_next = (beats_left >= 13'(BURST_LEN)) ? 8'(BURST_LEN - 1) : 8'(beats_left - 13'd1);
  assign pop        = (fifo_count != '0) && bus.if_ready;

  always_comb begin
    for (int k = 0; k < IPB; k++) begin
      push_data[k] = {beat_fault, fetch_pc_q + ADDR_WIDTH'(4 * k), beat_shifted[32*k +: 32]};
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    drain_pend_d = drain_pend_q;
    push         = 1'b0;
    flush        = bus.redirect_valid;
    if (bus.redirect_valid) fetch_pc_d = bus.redirect_pc;
    case (state_q)
      IDLE: begin
        if (!bus.redirect_valid && fifo_count <= CNT_W'(FIFO_DEPTH - RESERVE)) begin
          state_d      = ADDR;
          araddr_d     = aligned_pc;
          arlen_d      = arlen_next;
          drain_pend_d = 1'b0;
        end
      end
      ADDR: begin
        if (bus.redirect_valid) drain_pend_d = 1'b1;
        if (bus.m_axi_arready) begin
          state_d      = (drain_pend_q || bus.redirect_valid) ? DRAIN : DATA;
          drain_pend_d = 1'b0;
        end
      end
      DATA: begin
        if (rx_beat) begin
          if (bus.redirect_valid) begin
            state_d = bus.m_axi_rlast ? IDLE : DRAIN;
          end else begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'({push_n, 2'b00});
            if (bus.m_axi_rlast) state_d = IDLE;
          end
        end else if (bus.redirect_valid) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rx_beat && bus.m_axi_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= entry;
      araddr_q     <= '0;
      arlen_q      <= '0;
      drain_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      drain_pend_q <= drain_pend_d;
    end
  end

  ifetch_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (FIFO_DEPTH),
    .IPB     (IPB)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_n    (push_n),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.m_axi_arid    = '0;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arsize  = 3'(BEAT_SHIFT);
  assign bus.m_axi_arburst = BURST_INCR;
  assign bus.m_axi_arvalid = (state_q == ADDR);
  assign bus.m_axi_rready  = (state_q == DATA) || (state_q == DRAIN);
  assign bus.if_instr      = head[31:0];
  assign bus.if_pc         = head[ADDR_WIDTH+31:32];
  assign bus.if_fault      = head[ENTRY_W-1];
  assign bus.if_valid      = (fifo_count != '0);

endmodule

// File: tb/tb_ifetch_burst_buffer.sv
// Directed bench for ifetch_burst_buffer with a scripted AXI read slave.
module tb_ifetch_burst_buffer;

  logic        clk;
  logic        reset;
  logic [63:0] entry;
  int          n_cmp;
  int          n_bad;

  logic [63:0] mon_pc[$];
  logic [31:0] mon_instr[$];
  logic        mon_fault[$];

  ifetch_burst_buffer_if #(.ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  ifetch_burst_buffer #(
    .ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64), .BURST_LEN(8), .FIFO_DEPTH(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .entry (entry),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && bus.if_valid && bus.if_ready) begin
      mon_pc.push_back(bus.if_pc);
      mon_instr.push_back(bus.if_instr);
      mon_fault.push_back(bus.if_fault);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return {16'h1357, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ar(input int budget);
    int n = 0;
    while (bus.m_axi_arvalid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (bus.m_axi_arvalid !== 1'b1) check("ar_timeout", {63'd0, bus.m_axi_arvalid}, 64'd1);
  endtask

  task automatic accept_ar();
    bus.m_axi_arready = 1'b1;
    step();
    bus.m_axi_arready = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] addr, input logic [1:0] resp, input logic last);
    int n = 0;
    bus.m_axi_rdata  = {instr_of(addr + 64'd4), instr_of(addr)};
    bus.m_axi_rresp  = resp;
    bus.m_axi_rlast  = last;
    bus.m_axi_rvalid = 1'b1;
    while (bus.m_axi_rready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bus.m_axi_rready !== 1'b1) check("rready_wait", {63'd0, bus.m_axi_rready}, 64'd1);
    step();
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast  = 1'b0;
  endtask

  task automatic clear_mon();
    mon_pc.delete();
    mon_instr.delete();
    mon_fault.delete();
  endtask

  initial begin
    logic [63:0] a;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    entry = 64'h8000_0000;
    bus.m_axi_arready  = 1'b0;
    bus.m_axi_rdata    = '0;
    bus.m_axi_rresp    = 2'b00;
    bus.m_axi_rlast    = 1'b0;
    bus.m_axi_rvalid   = 1'b0;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) step();

    check("rst_arvalid", {63'd0, bus.m_axi_arvalid}, 64'd0);
    check("rst_araddr", bus.m_axi_araddr, 64'd0);
    check("rst_arlen", {56'd0, bus.m_axi_arlen}, 64'd0);
    check("rst_rready", {63'd0, bus.m_axi_rready}, 64'd0);
    check("rst_if_valid", {63'd0, bus.if_valid}, 64'd0);
    check("rst_if_instr", {32'd0, bus.if_instr}, 64'd0);
    check("rst_if_pc", bus.if_pc, 64'd0);
    check("rst_if_fault", {63'd0, bus.if_fault}, 64'd0);

    // Burst 1 from 0x8000_0000 with SLVERR on the second beat, decode stalled.
    reset = 1'b1;
    wait_ar(20);
    check("b1_araddr", bus.m_axi_araddr, 64'h8000_0000);
    check("b1_arlen", {56'd0, bus.m_axi_arlen}, 64'd7);
    check("b1_arsize", {61'd0, bus.m_axi_arsize}, 64'd3);
    check("b1_arburst", {62'd0, bus.m_axi_arburst}, 64'd1);
    check("b1_arid", {51'd0, bus.m_axi_arid}, 64'd0);
    accept_ar();
    for (int i = 0; i < 8; i++) begin
      a = 64'h8000_0000 + 64'(8 * i);
      send_beat(a, (i == 1) ? 2'b10 : 2'b00, i == 7);
      if (i == 0) begin
        check("lat_if_valid", {63'd0, bus.if_valid}, 64'd1);
        check("lat_if_pc", bus.if_pc, 64'h8000_0000);
        check("lat_if_instr", {32'd0, bus.if_instr}, {32'd0, 32'h1357_0000});
      end
    end

    // FIFO full: no new request until all 16 entries are consumed.
    for (int i = 0; i < 10; i++) begin
      step();
      check("full_no_ar", {63'd0, bus.m_axi_arvalid}, 64'd0);
    end
    clear_mon();
    bus.if_ready = 1'b1;
    wait_ar(40);
    check("pops_before_ar", 64'(mon_pc.size()), 64'd16);
    bus.if_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < mon_pc.size()) begin
        a = 64'h8000_0000 + 64'(4 * i);
        check("b1_pc", mon_pc[i], a);
        check("b1_instr", {32'd0, mon_instr[i]}, {32'd0, instr_of(a)});
        check("b1_fault", {63'd0, mon_fault[i]}, (i == 2 || i == 3) ? 64'd1 : 64'd0);
      end
    end

    // Burst 2: AR payload stable under backpressure, then redirect after beat 3.
    check("b2_araddr", bus.m_axi_araddr, 64'h8000_0040);
    check("b2_arlen", {56'd0, bus.m_axi_arlen}, 64'd7);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_arvalid", {63'd0, bus.m_axi_arvalid}, 64'd1);
      check("hold_araddr", bus.m_axi_araddr, 64'h8000_0040);
      check("hold_arlen", {56'd0, bus.m_axi_arlen}, 64'd7);
    end
    accept_ar();
    for (int i = 0; i < 3; i++) send_beat(64'h8000_0040 + 64'(8 * i), 2'b00, 1'b0);
    check("pre_redir_valid", {63'd0, bus.if_valid}, 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_2000;
    step();
    bus.redirect_valid = 1'b0;
    check("redir_if_valid", {63'd0, bus.if_valid}, 64'd0);
    for (int i = 3; i < 8; i++) begin
      send_beat(64'h8000_0040 + 64'(8 * i), 2'b00, i == 7);
      check("drain_if_valid", {63'd0, bus.if_valid}, 64'd0);
    end
    wait_ar(20);
    check("b3_araddr", bus.m_axi_araddr, 64'h8000_2000);
    check("b3_arlen", {56'd0, bus.m_axi_arlen}, 64'd7);

    // Redirect while AR is pending: request stays up, its data is drained.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0FF4;
    step();
    bus.redirect_valid = 1'b0;
    check("ar_redir_arvalid", {63'd0, bus.m_axi_arvalid}, 64'd1);
    check("ar_redir_araddr", bus.m_axi_araddr, 64'h8000_2000);
    step();
    accept_ar();
    for (int i = 0; i < 8; i++) send_beat(64'h8000_2000 + 64'(8 * i), 2'b00, i == 7);
    check("ar_drain_if_valid", {63'd0, bus.if_valid}, 64'd0);

    // Near a 4 KB boundary: short burst, low slot of the first beat dropped.
    wait_ar(20);
    check("pg_araddr", bus.m_axi_araddr, 64'h8000_0FF0);
    check("pg_arlen", {56'd0, bus.m_axi_arlen}, 64'd1);
    accept_ar();
    send_beat(64'h8000_0FF0, 2'b00, 1'b0);
    check("pg_first_pc", bus.if_pc, 64'h8000_0FF4);
    check("pg_first_instr", {32'd0, bus.if_instr}, {32'd0, 32'h1357_0FF4});
    send_beat(64'h8000_0FF8, 2'b00, 1'b1);
    clear_mon();
    bus.if_ready = 1'b1;
    wait_ar(40);
    bus.if_ready = 1'b0;
    check("pg_pops", 64'(mon_pc.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < mon_pc.size()) begin
        a = 64'h8000_0FF4 + 64'(4 * i);
        check("pg_pc", mon_pc[i], a);
        check("pg_instr", {32'd0, mon_instr[i]}, {32'd0, instr_of(a)});
      end
    end
    check("pg_next_araddr", bus.m_axi_araddr, 64'h8000_1000);
    check("pg_next_arlen", {56'd0, bus.m_axi_arlen}, 64'd7);

    // Asynchronous reset in the middle of beat 5.
    accept_ar();
    for (int i = 0; i < 4; i++) send_beat(64'h8000_1000 + 64'(8 * i), 2'b00, 1'b0);
    check("mid_if_valid", {63'd0, bus.if_valid}, 64'd1);
    bus.m_axi_rdata  = {instr_of(64'h8000_1024), instr_of(64'h8000_1020)};
    bus.m_axi_rvalid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("async_arvalid", {63'd0, bus.m_axi_arvalid}, 64'd0);
    check("async_rready", {63'd0, bus.m_axi_rready}, 64'd0);
    check("async_if_valid", {63'd0, bus.if_valid}, 64'd0);
    check("async_araddr", bus.m_axi_araddr, 64'd0);
    bus.m_axi_rvalid = 1'b0;
    entry = 64'h8000_0100;
    repeat (3) step();
    reset = 1'b1;
    wait_ar(20);
    check("rel_araddr", bus.m_axi_araddr, 64'h8000_0100);
    check("rel_arlen", {56'd0, bus.m_axi_arlen}, 64'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
